reorder_buffer: RTL and testbench

In-order reorder buffer sitting directly downstream of the rename stage. It accepts one renamed instruction per cycle: destination architectural register, new physical register and previous physical mapping. It records out-of-order completion by ROB index and retires the oldest completed instruction once per cycle. On retirement it returns the superseded physical register to rename's free list over the `retire_valid`/`retire_phys_reg` pair.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 tb/tb_reorder_buffer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   ROB_DEPTH / IDX_W : number of entries and index width (ROB_DEPTH = 2**IDX_W)
//   PHYS_W / ARCH_W   : physical and architectural register tag widths
//   rob_idx_t         : ROB index type
//   rob_entry_t       : one ROB entry (valid, done, has_dest, arch_rd, phys_rd, old_phys_rd)
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int IDX_W     = 4;
  localparam int PHYS_W    = 6;
  localparam int ARCH_W    = 5;

  typedef logic [IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [ARCH_W-1:0] arch_rd;
    logic [PHYS_W-1:0] phys_rd;
    logic [PHYS_W-1:0] old_phys_rd;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order reorder buffer placed after rename.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   alloc_valid/ready     : allocation handshake (see below)
//   alloc_has_dest, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd : renamed instruction
//   alloc_rob_idx         : index the presented instruction receives (tail)
//   complete_valid, complete_rob_idx : execution completion by ROB index
//   retire_valid          : one-cycle pulse per retired instruction
//   retire_free           : retired instruction had a destination
//   retire_phys_reg       : superseded physical register to free
//   retire_new_phys_reg   : committed physical register
//   retire_arch_reg       : committed architectural register
//   rob_count, rob_empty  : occupancy
//
// Handshake: an instruction is accepted on a rising edge where alloc_valid
// and alloc_ready are both high. alloc_ready depends only on registered
// occupancy (count < ROB_DEPTH) and never on alloc_valid or on a retirement
// in the same cycle, so a full buffer refuses allocation even while it
// retires. Completion and retirement have no backpressure.
//
// The widths of the parameters must agree with rob_pkg, whose entry struct
// holds the per-entry state.
module reorder_buffer #(
  parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
  parameter int IDX_W     = rob_pkg::IDX_W,
  parameter int PHYS_W    = rob_pkg::PHYS_W,
  parameter int ARCH_W    = rob_pkg::ARCH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_has_dest,
  input  logic [ARCH_W-1:0] alloc_arch_rd,
  input  logic [PHYS_W-1:0] alloc_phys_rd,
  input  logic [PHYS_W-1:0] alloc_old_phys_rd,
  output logic [IDX_W-1:0]  alloc_rob_idx,
  input  logic              complete_valid,
  input  logic [IDX_W-1:0]  complete_rob_idx,
  output logic              retire_valid,
  output logic              retire_free,
  output logic [PHYS_W-1:0] retire_phys_reg,
  output logic [PHYS_W-1:0] retire_new_phys_reg,
  output logic [ARCH_W-1:0] retire_arch_reg,
  output logic [IDX_W:0]    rob_count,
  output logic              rob_empty
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

  rob_pkg::rob_entry_t entries_q [ROB_DEPTH];
  rob_pkg::rob_entry_t entries_d [ROB_DEPTH];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic              retire_valid_q, retire_valid_d;
  logic              retire_free_q, retire_free_d;
  logic [PHYS_W-1:0] retire_phys_q, retire_phys_d;
  logic [PHYS_W-1:0] retire_new_phys_q, retire_new_phys_d;
  logic [ARCH_W-1:0] retire_arch_q, retire_arch_d;

  logic alloc_fire;
  logic retire_fire;

  assign alloc_ready   = (count_q != FULL_CNT);
  assign alloc_rob_idx = tail_q;
  assign rob_count     = count_q;
  assign rob_empty     = (count_q == '0);

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign retire_fire = entries_q[head_q].valid && entries_q[head_q].done;

  // Entry array update. The updates never collide on a live entry:
  // completion only lands on entries that are already valid, the tail slot
  // is never valid while allocation is possible, and a retiring head is
  // already done so a same-cycle completion to it changes nothing.
  always_comb begin
    entries_d = entries_q;
    if (complete_valid && entries_q[complete_rob_idx].valid) begin
      entries_d[complete_rob_idx].done = 1'b1;
    end
    if (retire_fire) begin
      entries_d[head_q].valid = 1'b0;
    end
    if (alloc_fire) begin
      entries_d[tail_q] = {1'b1, 1'b0, alloc_has_dest, alloc_arch_rd,
                           alloc_phys_rd, alloc_old_phys_rd};
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (retire_fire) head_d = head_q + IDX_W'(1);
    if (alloc_fire)  tail_d = tail_q + IDX_W'(1);
    case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + (IDX_W+1)'(1);
      2'b01:   count_d = count_q - (IDX_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Retire payload is registered; it holds its last value between pulses.
  always_comb begin
    retire_valid_d    = retire_fire;
    retire_free_d     = retire_free_q;
    retire_phys_d     = retire_phys_q;
    retire_new_phys_d = retire_new_phys_q;
    retire_arch_d     = retire_arch_q;
    if (retire_fire) begin
      retire_free_d     = entries_q[head_q].has_dest;
      retire_phys_d     = entries_q[head_q].old_phys_rd;
      retire_new_phys_d = entries_q[head_q].phys_rd;
      retire_arch_d     = entries_q[head_q].arch_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      retire_valid_q    <= 1'b0;
      retire_free_q     <= 1'b0;
      retire_phys_q     <= '0;
      retire_new_phys_q <= '0;
      retire_arch_q     <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      retire_valid_q    <= retire_valid_d;
      retire_free_q     <= retire_free_d;
      retire_phys_q     <= retire_phys_d;
      retire_new_phys_q <= retire_new_phys_d;
      retire_arch_q     <= retire_arch_d;
    end
  end

  assign retire_valid        = retire_valid_q;
  assign retire_free         = retire_free_q;
  assign retire_phys_reg     = retire_phys_q;
  assign retire_new_phys_reg = retire_new_phys_q;
  assign retire_arch_reg     = retire_arch_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random
// traffic, with a program-order reference model and a retire scoreboard.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int PW    = 6;
  localparam int AW    = 5;
  localparam int EW    = 1 + PW + PW + AW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic          alloc_has_dest = 1'b0;
  logic [AW-1:0] alloc_arch_rd = '0;
  logic [PW-1:0] alloc_phys_rd = '0;
  logic [PW-1:0] alloc_old_phys_rd = '0;
  logic [IW-1:0] alloc_rob_idx;
  logic          complete_valid = 1'b0;
  logic [IW-1:0] complete_rob_idx = '0;
  logic          retire_valid;
  logic          retire_free;
  logic [PW-1:0] retire_phys_reg;
  logic [PW-1:0] retire_new_phys_reg;
  logic [AW-1:0] retire_arch_reg;
  logic [IW:0]   rob_count;
  logic          rob_empty;

  reorder_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .alloc_valid         (alloc_valid),
    .alloc_ready         (alloc_ready),
    .alloc_has_dest      (alloc_has_dest),
    .alloc_arch_rd       (alloc_arch_rd),
    .alloc_phys_rd       (alloc_phys_rd),
    .alloc_old_phys_rd   (alloc_old_phys_rd),
    .alloc_rob_idx       (alloc_rob_idx),
    .complete_valid      (complete_valid),
    .complete_rob_idx    (complete_rob_idx),
    .retire_valid        (retire_valid),
    .retire_free         (retire_free),
    .retire_phys_reg     (retire_phys_reg),
    .retire_new_phys_reg (retire_new_phys_reg),
    .retire_arch_reg     (retire_arch_reg),
    .rob_count           (rob_count),
    .rob_empty           (rob_empty)
  );

  // reference model: outstanding instructions in program order
  typedef struct {
    int idx;
    bit has_dest;
    int arch;
    int phys;
    int old;
    bit done;
  } rec_t;

  rec_t           ord_q[$];
  int             tail_m = 0;
  logic [EW-1:0]  exp_q[$];
  int             checks = 0;
  int             errors = 0;
  bit             mon_en = 1'b0;

  function automatic logic [EW-1:0] pack_ret(bit f, int old, int nw, int arch);
    return {f, PW'(old), PW'(nw), AW'(arch)};
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT sees.
  task automatic model_edge();
    int pre_size;
    if (reset) begin
      ord_q.delete();
      exp_q.delete();
      tail_m = 0;
      return;
    end
    pre_size = ord_q.size();
    if (pre_size > 0 && ord_q[0].done) begin
      exp_q.push_back(pack_ret(ord_q[0].has_dest, ord_q[0].old, ord_q[0].phys, ord_q[0].arch));
      void'(ord_q.pop_front());
    end
    if (complete_valid) begin
      foreach (ord_q[i]) begin
        if (ord_q[i].idx == int'(complete_rob_idx)) ord_q[i].done = 1'b1;
      end
    end
    if (alloc_valid && pre_size < DEPTH) begin
      rec_t r;
      r.idx = tail_m;
      r.has_dest = alloc_has_dest;
      r.arch = int'(alloc_arch_rd);
      r.phys = int'(alloc_phys_rd);
      r.old = int'(alloc_old_phys_rd);
      r.done = 1'b0;
      ord_q.push_back(r);
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  // driver: apply one cycle of inputs
  task automatic step(bit av, bit hd, int arch, int phys, int old, bit cv, int cidx);
    alloc_valid       = av;
    alloc_has_dest    = hd;
    alloc_arch_rd     = AW'(arch);
    alloc_phys_rd     = PW'(phys);
    alloc_old_phys_rd = PW'(old);
    complete_valid    = cv;
    complete_rob_idx  = IW'(cidx);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && ord_q.size() > 0; k++) begin
      int pick;
      pick = -1;
      foreach (ord_q[i]) begin
        if (pick < 0 && !ord_q[i].done) pick = ord_q[i].idx;
      end
      if (pick >= 0) step(0, 0, 0, 0, 0, 1, pick);
      else idle();
    end
    idle();
    idle();
    check("drain_timeout", ord_q.size(), 0);
  endtask

  // scoreboard monitor, away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      check("rob_count", rob_count, ord_q.size());
      check("rob_empty", rob_empty, ord_q.size() == 0);
      check("alloc_ready", alloc_ready, ord_q.size() < DEPTH);
      check("alloc_rob_idx", alloc_rob_idx, tail_m);
      if (retire_valid) begin
        if (exp_q.size() == 0) begin
          check("retire_unexpected", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("retire_payload", {retire_free, retire_phys_reg, retire_new_phys_reg, retire_arch_reg}, e);
        end
      end else if (exp_q.size() > 0) begin
        check("retire_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    check("rst_empty", rob_empty, 1);
    check("rst_ready", alloc_ready, 1);
    check("rst_retire_valid", retire_valid, 0);
    check("rst_rob_idx", alloc_rob_idx, 0);
    check("rst_retire_payload", {retire_free, retire_phys_reg, retire_new_phys_reg, retire_arch_reg}, 0);
    mon_en = 1'b1;

    // basic retire
    step(1, 1, 3, 32, 3, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("basic_not_yet", retire_valid, 0);
    idle();
    check("basic_pulse", retire_valid, 1);
    check("basic_phys", retire_phys_reg, 3);
    check("basic_new_phys", retire_new_phys_reg, 32);
    check("basic_arch", retire_arch_reg, 3);
    check("basic_free", retire_free, 1);
    idle();
    check("basic_one_cycle", retire_valid, 0);

    // out-of-order completion
    for (int i = 0; i < 3; i++) step(1, 1, 10 + i, 40 + i, 20 + i, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 1, 2);
    check("ooo_wait", retire_valid, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) idle();

    // full
    for (int i = 0; i < DEPTH; i++) step(1, 1, i, i + 1, i + 2, 0, 0);
    check("full_ready", alloc_ready, 0);
    check("full_count", rob_count, DEPTH);
    step(1, 1, 31, 63, 63, 0, 0);
    check("full_17th_count", rob_count, DEPTH);
    step(0, 0, 0, 0, 0, 1, alloc_rob_idx);
    check("full_ready_before_retire", alloc_ready, 0);
    step(1, 1, 30, 62, 61, 0, 0);
    check("full_no_bypass_count", rob_count, DEPTH - 1);
    check("full_ready_after_retire", alloc_ready, 1);
    drain();

    // wrap-around: back-to-back alloc with completion of the previous one
    for (int i = 0; i < 40; i++) begin
      int prev;
      prev = (tail_m + DEPTH - 1) % DEPTH;
      step(1, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 63),
           $urandom_range(0, 63), i > 0, prev);
    end
    drain();

    // edge cases: completion to invalid entries, no-destination retire
    step(0, 0, 0, 0, 0, 1, 5);
    check("inv_complete_count", rob_count, 0);
    step(1, 0, 7, 9, 11, 0, 0);
    step(0, 0, 0, 0, 0, 1, (tail_m + 1) % DEPTH);
    step(0, 0, 0, 0, 0, 1, (tail_m + DEPTH - 1) % DEPTH);
    idle();
    check("nodest_free", retire_free, 0);
    drain();

    // random traffic with a mid-run reset
    for (int c = 0; c < 1500; c++) begin
      bit av, cv;
      int cidx;
      if (c == 700) begin
        reset = 1'b1;
        step(1, 1, 1, 1, 1, 1, 0);
        reset = 1'b0;
        check("midreset_pulse", retire_valid, 0);
        check("midreset_count", rob_count, 0);
      end
      av = $urandom_range(0, 9) < 7;
      cv = $urandom_range(0, 9) < 6;
      if (ord_q.size() > 0 && $urandom_range(0, 3) != 0)
        cidx = ord_q[$urandom_range(0, ord_q.size() - 1)].idx;
      else
        cidx = $urandom_range(0, DEPTH - 1);
      step(av, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 63),
           $urandom_range(0, 63), cv, cidx);
    end
    drain();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
